// File: rtl/axis_golden_checker_if.sv
// rtl/axis_golden_checker_if.sv - DUT and golden stream bundle for the golden checker
interface axis_golden_checker_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] dut_data;
    logic                  dut_valid;
    logic                  dut_last;
    logic                  dut_ready;
    logic [DATA_WIDTH-1:0] ref_data;
    logic                  ref_valid;
    logic                  ref_ready;

    modport master (
        output dut_data, dut_valid, dut_last, ref_data, ref_valid,
        input  dut_ready, ref_ready
    );

    modport slave (
        input  dut_data, dut_valid, dut_last, ref_data, ref_valid,
        output dut_ready, ref_ready
    );
endinterface

// File: rtl/axis_golden_checker.sv
// rtl/axis_golden_checker.sv - lock-step beat comparison of a DUT stream against a golden stream
// Reports mismatch statistics, framing errors, a rotate-XOR checksum and a watchdog timeout.
module axis_golden_checker #(
    parameter int          DATA_WIDTH     = 64,
    parameter int          EXPECTED_WORDS = 841,
    parameter int          CNT_WIDTH      = 32,
    parameter int          TIMEOUT_CYCLES = 495000,
    parameter int          STALL_MODE     = 0,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_golden_checker_if.slave  chk,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  failed,
    output logic                  timeout,
    output logic                  last_early,
    output logic                  last_missing,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  mismatch_count,
    output logic [CNT_WIDTH-1:0]  first_mismatch_idx,
    output logic [DATA_WIDTH-1:0] checksum
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(EXPECTED_WORDS - 1);
    localparam logic [CNT_WIDTH-1:0] TO_LAST  =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam bit WDOG_EN  = (TIMEOUT_CYCLES > 0);
    localparam bit STALL_EN = (STALL_MODE != 0);

    logic [1:0]            state_q, state_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [CNT_WIDTH-1:0]  timer_q, timer_d;
    logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
    logic [CNT_WIDTH-1:0]  mismatch_q, mismatch_d;
    logic [CNT_WIDTH-1:0]  first_idx_q, first_idx_d;
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
    logic                  done_q, done_d;
    logic                  failed_q, failed_d;
    logic                  timeout_q, timeout_d;
    logic                  early_q, early_d;
    logic                  missing_q, missing_d;

    logic run, accept, beat, at_last, lfsr_fb, end_frame;

    assign run     = (state_q == S_RUN);
    assign accept  = !STALL_EN || lfsr_q[0];
    assign beat    = run && chk.dut_valid && chk.ref_valid && accept;
    assign at_last = (word_count_q == LAST_IDX);
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Each ready depends on the other side's valid so a beat only ever consumes both streams together.
    assign chk.dut_ready = run && chk.ref_valid && accept;
    assign chk.ref_ready = run && chk.dut_valid && accept;

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        timer_d      = timer_q;
        word_count_d = word_count_q;
        mismatch_d   = mismatch_q;
        first_idx_d  = first_idx_q;
        checksum_d   = checksum_q;
        done_d       = done_q;
        failed_d     = failed_q;
        timeout_d    = timeout_q;
        early_d      = early_q;
        missing_d    = missing_q;
        end_frame    = 1'b0;

        case (state_q)
            S_RUN: begin
                lfsr_d  = {lfsr_q[14:0], lfsr_fb};
                timer_d = timer_q + CNT_ONE;
                if (beat) begin
                    word_count_d = word_count_q + CNT_ONE;
                    checksum_d   = {checksum_q[DATA_WIDTH-2:0], checksum_q[DATA_WIDTH-1]} ^ chk.dut_data;
                    if (chk.dut_data != chk.ref_data) begin
                        if (mismatch_q != '1) mismatch_d = mismatch_q + CNT_ONE;
                        if (mismatch_q == '0) first_idx_d = word_count_q;
                    end
                    if (chk.dut_last && !at_last) begin
                        early_d   = 1'b1;
                        end_frame = 1'b1;
                    end else if (at_last) begin
                        missing_d = !chk.dut_last;
                        end_frame = 1'b1;
                    end
                end
                // A terminating beat takes priority over a watchdog expiring in the same cycle.
                if (end_frame) begin
                    state_d = S_DONE;
                end else if (WDOG_EN && (timer_q == TO_LAST)) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
                if (state_d == S_DONE) begin
                    done_d   = 1'b1;
                    failed_d = (mismatch_d != '0) || early_d || missing_d || timeout_d;
                end
            end
            default: begin
                if (start) begin
                    state_d      = S_RUN;
                    lfsr_d       = LFSR_SEED;
                    timer_d      = '0;
                    word_count_d = '0;
                    mismatch_d   = '0;
                    first_idx_d  = '1;
                    checksum_d   = '0;
                    done_d       = 1'b0;
                    failed_d     = 1'b0;
                    timeout_d    = 1'b0;
                    early_d      = 1'b0;
                    missing_d    = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lfsr_q       <= LFSR_SEED;
            timer_q      <= '0;
            word_count_q <= '0;
            mismatch_q   <= '0;
            first_idx_q  <= '1;
            checksum_q   <= '0;
            done_q       <= 1'b0;
            failed_q     <= 1'b0;
            timeout_q    <= 1'b0;
            early_q      <= 1'b0;
            missing_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            timer_q      <= timer_d;
            word_count_q <= word_count_d;
            mismatch_q   <= mismatch_d;
            first_idx_q  <= first_idx_d;
            checksum_q   <= checksum_d;
            done_q       <= done_d;
            failed_q     <= failed_d;
            timeout_q    <= timeout_d;
            early_q      <= early_d;
            missing_q    <= missing_d;
        end
    end

    assign busy               = run;
    assign done               = done_q;
    assign failed             = failed_q;
    assign timeout            = timeout_q;
    assign last_early         = early_q;
    assign last_missing       = missing_q;
    assign word_count         = word_count_q;
    assign mismatch_count     = mismatch_q;
    assign first_mismatch_idx = first_idx_q;
    assign checksum           = checksum_q;
endmodule

// File: tb/tb_axis_golden_checker.sv
// tb/tb_axis_golden_checker.sv - scoreboard bench for axis_golden_checker
module tb_axis_golden_checker;
    localparam int DW = 64;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic start0, start1;
    logic busy0, done0, failed0, timeout0, early0, missing0;
    logic busy1, done1, failed1, timeout1, early1, missing1;
    logic [CW-1:0] wc0, mc0, fi0, wc1, mc1, fi1;
    logic [DW-1:0] ck0, ck1;

    axis_golden_checker_if #(.DATA_WIDTH(DW)) bus0 ();
    axis_golden_checker_if #(.DATA_WIDTH(DW)) bus1 ();

    axis_golden_checker #(
        .DATA_WIDTH(DW), .EXPECTED_WORDS(8), .CNT_WIDTH(CW),
        .TIMEOUT_CYCLES(100), .STALL_MODE(0), .LFSR_SEED(16'hACE1)
    ) u0 (
        .clk(clk), .rst(rst), .chk(bus0), .start(start0),
        .busy(busy0), .done(done0), .failed(failed0), .timeout(timeout0),
        .last_early(early0), .last_missing(missing0),
        .word_count(wc0), .mismatch_count(mc0), .first_mismatch_idx(fi0), .checksum(ck0)
    );

    axis_golden_checker #(
        .DATA_WIDTH(DW), .EXPECTED_WORDS(841), .CNT_WIDTH(CW),
        .TIMEOUT_CYCLES(0), .STALL_MODE(1), .LFSR_SEED(16'hACE1)
    ) u1 (
        .clk(clk), .rst(rst), .chk(bus1), .start(start1),
        .busy(busy1), .done(done1), .failed(failed1), .timeout(timeout1),
        .last_early(early1), .last_missing(missing1),
        .word_count(wc1), .mismatch_count(mc1), .first_mismatch_idx(fi1), .checksum(ck1)
    );

    typedef struct {
        logic          failed, timeout, early, missing;
        logic [CW-1:0] wc, mc, fi;
        logic [DW-1:0] ck;
        int            lat;
    } res_t;

    res_t q0[$];
    res_t q1[$];
    res_t e0, e1;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic res_t mk(input logic f, input logic t, input logic e, input logic m,
                                input logic [CW-1:0] wc, input logic [CW-1:0] mc,
                                input logic [CW-1:0] fi, input logic [DW-1:0] ck, input int lat);
        res_t r;
        r.failed = f; r.timeout = t; r.early = e; r.missing = m;
        r.wc = wc; r.mc = mc; r.fi = fi; r.ck = ck; r.lat = lat;
        return r;
    endfunction

    function automatic logic [DW-1:0] rotx(input logic [DW-1:0] c, input logic [DW-1:0] d);
        return {c[DW-2:0], c[DW-1]} ^ d;
    endfunction

    function automatic logic [DW-1:0] d0(input int i, input logic [7:0] bad);
        logic [DW-1:0] v;
        v = DW'(i);
        if (bad[i[2:0]]) v = v ^ 64'hFF00;
        return v;
    endfunction

    function automatic logic [DW-1:0] d1(input int i);
        return DW'(i) * 64'h9E37_79B9_7F4A_7C15 + 64'h5A5A;
    endfunction

    function automatic logic [DW-1:0] model_ck0(input int nb, input logic [7:0] bad);
        logic [DW-1:0] c = '0;
        for (int i = 0; i < nb; i++) c = rotx(c, d0(i, bad));
        return c;
    endfunction

    function automatic logic [DW-1:0] model_ck1(input int nb);
        logic [DW-1:0] c = '0;
        for (int i = 0; i < nb; i++) c = rotx(c, d1(i));
        return c;
    endfunction

    task automatic cmp_res(input string tag, input res_t e, input logic f, input logic t,
                           input logic el, input logic ms, input logic [CW-1:0] wc,
                           input logic [CW-1:0] mc, input logic [CW-1:0] fi,
                           input logic [DW-1:0] ck, input logic bz, input int lat);
        check({tag, ".failed"}, 64'(f), 64'(e.failed));
        check({tag, ".timeout"}, 64'(t), 64'(e.timeout));
        check({tag, ".last_early"}, 64'(el), 64'(e.early));
        check({tag, ".last_missing"}, 64'(ms), 64'(e.missing));
        check({tag, ".word_count"}, 64'(wc), 64'(e.wc));
        check({tag, ".mismatch_count"}, 64'(mc), 64'(e.mc));
        check({tag, ".first_idx"}, 64'(fi), 64'(e.fi));
        check({tag, ".checksum"}, ck, e.ck);
        check({tag, ".busy"}, 64'(bz), 64'(0));
        if (e.lat >= 0) check({tag, ".latency"}, 64'(lat), 64'(e.lat));
    endtask

    // Result monitors: pop the expected record whenever done rises.
    logic done0_p = 1'b0, done1_p = 1'b0;
    int lat0 = 0;
    always @(negedge clk) begin
        if (start0 && !busy0) lat0 = -1;
        else lat0++;
        if (done0 && !done0_p) begin
            if (q0.size() == 0) check("u0_unexpected_done", 64'(1), 64'(0));
            else begin
                e0 = q0.pop_front();
                cmp_res("u0", e0, failed0, timeout0, early0, missing0, wc0, mc0, fi0, ck0, busy0, lat0);
            end
        end
        done0_p = done0;
    end

    logic [15:0] lm = 16'hACE1;
    int rdy_err = 0;
    int stalls = 0;
    always @(negedge clk) begin
        if (busy1) begin
            if (bus1.dut_ready !== (bus1.ref_valid & lm[0])) rdy_err++;
            if (!lm[0]) stalls++;
            lm = {lm[14:0], lm[15] ^ lm[13] ^ lm[12] ^ lm[10]};
        end else if (start1) begin
            lm = 16'hACE1;
        end
        if (done1 && !done1_p) begin
            if (q1.size() == 0) check("u1_unexpected_done", 64'(1), 64'(0));
            else begin
                e1 = q1.pop_front();
                cmp_res("u1", e1, failed1, timeout1, early1, missing1, wc1, mc1, fi1, ck1, busy1, -1);
            end
        end
        done1_p = done1;
    end

    task automatic pulse_start(input int sel);
        @(posedge clk); #1;
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic frame0(input int nb, input logic [7:0] bad, input int last_at, input int mid_start);
        int g;
        pulse_start(0);
        for (int i = 0; i < nb; i++) begin
            bus0.dut_valid = 1'b1;
            bus0.ref_valid = 1'b1;
            bus0.ref_data  = DW'(i);
            bus0.dut_data  = d0(i, bad);
            bus0.dut_last  = (i == last_at);
            start0         = (i == mid_start);
            g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (!(bus0.dut_ready && bus0.ref_ready) && g < 50);
            if (!(bus0.dut_ready && bus0.ref_ready)) check("u0_beat_handshake", 64'(0), 64'(1));
            @(posedge clk); #1;
        end
        start0         = 1'b0;
        bus0.dut_valid = 1'b0;
        bus0.ref_valid = 1'b0;
        bus0.dut_last  = 1'b0;
    endtask

    task automatic wait_done(input int sel);
        int g = 0;
        while (((sel == 0) ? done0 : done1) !== 1'b1 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 5000) check("wait_done", 64'(0), 64'(1));
        @(negedge clk);
    endtask

    initial begin
        int idx, guard;
        logic hs;
        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        bus0.dut_valid = 1'b0; bus0.ref_valid = 1'b0; bus0.dut_last = 1'b0;
        bus0.dut_data = '0; bus0.ref_data = '0;
        bus1.dut_valid = 1'b0; bus1.ref_valid = 1'b0; bus1.dut_last = 1'b0;
        bus1.dut_data = '0; bus1.ref_data = '0;
        repeat (2) @(negedge clk);
        check("rst.busy", 64'(busy0), 64'(0));
        check("rst.done", 64'(done0), 64'(0));
        check("rst.failed", 64'(failed0), 64'(0));
        check("rst.word_count", 64'(wc0), 64'(0));
        check("rst.first_idx", 64'(fi0), 64'hFFFF_FFFF);
        check("rst.checksum", ck0, 64'(0));
        @(posedge clk); #1 rst = 1'b0;

        q0.push_back(mk(0, 0, 0, 0, 8, 0, 32'hFFFF_FFFF, model_ck0(8, 8'h00), -1));
        frame0(8, 8'h00, 7, -1);
        wait_done(0);

        q0.push_back(mk(1, 0, 0, 0, 8, 2, 3, model_ck0(8, 8'b0010_1000), -1));
        frame0(8, 8'b0010_1000, 7, -1);
        wait_done(0);

        q0.push_back(mk(1, 0, 1, 0, 5, 0, 32'hFFFF_FFFF, model_ck0(5, 8'h00), -1));
        frame0(5, 8'h00, 4, -1);
        wait_done(0);

        q0.push_back(mk(1, 0, 0, 1, 8, 0, 32'hFFFF_FFFF, model_ck0(8, 8'h00), -1));
        frame0(8, 8'h00, -1, -1);
        wait_done(0);

        q0.push_back(mk(1, 1, 0, 0, 3, 0, 32'hFFFF_FFFF, model_ck0(3, 8'h00), 100));
        frame0(3, 8'h00, -1, -1);
        wait_done(0);

        // Restart from DONE after a timeout, with a stray start mid-frame.
        q0.push_back(mk(0, 0, 0, 0, 8, 0, 32'hFFFF_FFFF, model_ck0(8, 8'h00), -1));
        frame0(8, 8'h00, 7, 3);
        wait_done(0);

        q1.push_back(mk(0, 0, 0, 0, 841, 0, 32'hFFFF_FFFF, model_ck1(841), -1));
        bus1.ref_valid = 1'b1;
        bus1.ref_data  = d1(0);
        bus1.dut_data  = d1(0);
        bus1.dut_valid = 1'($urandom_range(0, 1));
        bus1.dut_last  = 1'b0;
        pulse_start(1);
        idx = 0;
        guard = 0;
        while (idx < 841 && guard < 20000) begin
            @(negedge clk);
            hs = bus1.dut_valid && bus1.dut_ready && bus1.ref_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            bus1.dut_valid = 1'($urandom_range(0, 1));
            bus1.ref_data  = d1(idx);
            bus1.dut_data  = d1(idx);
            bus1.dut_last  = (idx == 840);
            guard++;
        end
        bus1.dut_valid = 1'b0;
        bus1.dut_last  = 1'b0;
        check("u1_all_beats_sent", 64'(idx), 64'(841));
        wait_done(1);
        check("u1_ready_trace_errors", 64'(rdy_err), 64'(0));
        check("u1_stalls_seen", 64'(stalls > 0), 64'(1));

        pulse_start(1);
        bus1.dut_valid = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("pre_rst.busy", 64'(busy1), 64'(1));
        check("pre_rst.word_count_nonzero", 64'(wc1 != 0), 64'(1));
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("async_rst.busy", 64'(busy1), 64'(0));
        check("async_rst.word_count", 64'(wc1), 64'(0));
        check("async_rst.first_idx", 64'(fi1), 64'hFFFF_FFFF);
        check("async_rst.checksum", ck1, 64'(0));
        check("async_rst.dut_ready", 64'(bus1.dut_ready), 64'(0));
        check("async_rst.done0", 64'(done0), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        bus1.dut_valid = 1'b0;
        bus1.ref_valid = 1'b0;
        repeat (2) @(negedge clk);

        check("q0_drained", 64'(q0.size()), 64'(0));
        check("q1_drained", 64'(q1.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end
endmodule

// File: doc/axis_golden_checker.md
Name: axis_golden_checker

Overview:
Parametrised AXI-stream golden-comparison checker for FPGA self-test harnesses. It consumes the core's output stream and a golden reference stream (typically from a ROM FIFO) in lock-step and compares them beat-by-beat. It reports pass/fail, mismatch statistics, TLAST framing errors, a running checksum and a watchdog timeout. Optional pseudo-random back-pressure stresses the DUT output path. One instance per output channel; a top-level sequencer drives start and collects results.

Parameters:
DATA_WIDTH, 64, width of DUT and reference data.
EXPECTED_WORDS, 841, beats in one frame; the last beat must carry dut_last.
CNT_WIDTH, 32, width of all counters and index outputs.
TIMEOUT_CYCLES, 495000, cycles allowed in RUN before timeout; 0 disables the watchdog.
STALL_MODE, 0, back-pressure mode: 0 = always accept; 1 = accept only when LFSR bit 0 is 1.
LFSR_SEED, 16'hACE1, non-zero seed of the 16-bit Fibonacci LFSR (taps 16,14,13,11).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle pulse; arms a new check
dut_data  in  DATA_WIDTH  DUT output data
dut_valid  in  1  DUT output valid
dut_last  in  1  DUT output last
dut_ready  out  1  ready to the DUT
ref_data  in  DATA_WIDTH  golden data
ref_valid  in  1  golden valid
ref_ready  out  1  ready to the golden source
busy  out  1  high in RUN
done  out  1  sticky; check complete
failed  out  1  sticky; any error (mismatch, framing, timeout)
timeout  out  1  sticky; watchdog expired
last_early  out  1  sticky; dut_last seen before beat EXPECTED_WORDS
last_missing  out  1  sticky; beat EXPECTED_WORDS had no dut_last
word_count  out  CNT_WIDTH  beats compared
mismatch_count  out  CNT_WIDTH  mismatching beats, saturating at all-ones
first_mismatch_idx  out  CNT_WIDTH  0-based index of the first mismatch; all-ones if none
checksum  out  DATA_WIDTH  rotate-XOR accumulation of dut_data

Behaviour:
- Reset (async assert): state IDLE; all outputs 0, except first_mismatch_idx = all-ones; LFSR = LFSR_SEED.
- States: IDLE, RUN, DONE.
  - IDLE: start -> RUN.
  - DONE: start -> RUN. Entry to RUN clears all statistics and sticky flags and reloads the LFSR.
  - RUN: start is ignored.
- accept = (STALL_MODE==0) | lfsr[0]. The LFSR advances every cycle in RUN.
- dut_ready = RUN & ref_valid & accept; ref_ready = RUN & dut_valid & accept. A beat occurs when both handshakes fire, so both streams advance together. A lone valid is never consumed.
- On each beat, registered with 1-cycle latency to outputs:
  - word_count++.
  - checksum <= rotl1(checksum) ^ dut_data.
  - If dut_data != ref_data: mismatch_count++ (saturating); if this is the first mismatch, capture first_mismatch_idx = the pre-increment word_count.
- Framing, evaluated on a beat with index n = pre-increment word_count:
  - dut_last with n+1 < EXPECTED_WORDS: set last_early and go to DONE.
  - n+1 == EXPECTED_WORDS without dut_last: set last_missing and go to DONE.
  - n+1 == EXPECTED_WORDS with dut_last: go to DONE.
  - The comparison on the terminating beat still counts.
- Watchdog: a cycle counter cleared on entry to RUN. When it reaches TIMEOUT_CYCLES in RUN, set timeout and go to DONE. If the final beat and timeout occur in the same cycle, the beat wins and timeout stays 0.
- On entry to DONE:
  - done = 1.
  - failed = (mismatch_count != 0) | last_early | last_missing | timeout, including the final beat's result.
  - busy = 0.
- Reset mid-RUN aborts immediately to the reset values; no partial result is retained.

Test Plan:
- STALL_MODE=0, EXPECTED_WORDS=8: identical streams 0..7, dut_last on beat 7 -> done=1, failed=0, word_count=8, mismatch_count=0, first_mismatch_idx=all-ones, checksum matches the software model.
- Corrupt beats 3 and 5 of an 8-beat frame -> mismatch_count=2, first_mismatch_idx=3, failed=1, done=1.
- dut_last on beat 4 of 8 -> last_early=1, word_count=5, done=1, failed=1. No dut_last on beat 7 -> last_missing=1, failed=1.
- TIMEOUT_CYCLES=100, DUT stalls after 3 beats -> timeout=1, failed=1, done=1 exactly 100 cycles after start, word_count=3.
- STALL_MODE=1 with ref_valid held high and a random dut_valid over 841 beats -> dut_ready follows the LFSR; no beat lost or duplicated; failed=0. Reset asserted mid-frame -> outputs return to reset values asynchronously.
- start while in RUN -> ignored. start in DONE -> flags and counters cleared, and a second clean run passes.
